spike_count_classifier: RTL and testbench

// Downstream consumer of the IF output layer. Integrates each output neuron's spike_out

---
 rtl/spike_count_classifier_if.sv | 31 +++
 rtl/spike_count_classifier.sv | 152 +++++++++++++++
 tb/tb_spike_count_classifier.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_count_classifier_if.sv
// Result port of the spike-count classifier: valid/ready handshake plus winner fields.
interface spike_count_classifier_if #(
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned IDX_WIDTH   = 4
) ();
    logic                   result_valid;
    logic                   result_ready;
    logic [IDX_WIDTH-1:0]   winner_idx;
    logic [COUNT_WIDTH-1:0] winner_count;
    logic                   tie;
    logic                   no_spike;

    // Classifier drives the result, consumer drives ready.
    modport master (
        output result_valid,
        output winner_idx,
        output winner_count,
        output tie,
        output no_spike,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  winner_idx,
        input  winner_count,
        input  tie,
        input  no_spike,
        output result_ready
    );
endinterface

// File: rtl/spike_count_classifier.sv
// Spike-count classifier: integrates each output neuron's spikes over a fixed window,
// then scans the counters one per cycle to pick the most active neuron (lowest index
// wins ties) and presents it on a valid/ready result port.
module spike_count_classifier #(
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned NUM_STEPS   = 100,
    localparam int unsigned IDX_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [NUM_NEURONS-1:0] spike_in_i,
    output logic                   busy_o,
    input  logic [IDX_WIDTH-1:0]   cnt_sel_i,
    output logic [COUNT_WIDTH-1:0] cnt_dout_o,
    spike_count_classifier_if.master res
);

    localparam int unsigned STEP_WIDTH = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [COUNT_WIDTH-1:0] CntMax = {COUNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StCount, StScan, StDone} state_e;

    state_e                 state_q;
    logic [STEP_WIDTH-1:0]  step_q;
    logic [IDX_WIDTH-1:0]   scan_idx_q;
    logic [COUNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
    logic [COUNT_WIDTH-1:0] cnt_d [NUM_NEURONS];
    logic [IDX_WIDTH-1:0]   best_idx_q;
    logic [COUNT_WIDTH-1:0] best_cnt_q;
    logic                   tie_q;
    logic                   no_spike_q;
    logic                   valid_q;
    logic                   busy_q;

    logic [COUNT_WIDTH-1:0] scan_cnt;
    logic                   scan_take;
    logic [COUNT_WIDTH-1:0] scan_best;
    logic                   scan_last;
    logic                   step_last;

    // Scan datapath: compare the currently addressed counter with the running best.
    always_comb begin
        scan_cnt  = cnt_q[scan_idx_q];
        scan_take = scan_cnt > best_cnt_q;
        scan_best = scan_take ? scan_cnt : best_cnt_q;
        scan_last = scan_idx_q == IDX_WIDTH'(NUM_NEURONS - 1);
        step_last = step_q == STEP_WIDTH'(NUM_STEPS - 1);
    end

    // Counter next state: clear on an accepted start, saturating accumulate while counting.
    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == StIdle && start_i) begin
                cnt_d[i] = '0;
            end else if (state_q == StCount && spike_in_i[i] && cnt_q[i] != CntMax) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Per-neuron spike counters; kept after the window for readback.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Control FSM with registered result fields and status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            step_q     <= '0;
            scan_idx_q <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
            tie_q      <= 1'b0;
            no_spike_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCount;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StCount: begin
                    step_q <= step_q + 1'b1;
                    if (step_last) begin
                        // Result fields restart here; they are the running best during the scan.
                        state_q    <= StScan;
                        scan_idx_q <= '0;
                        best_idx_q <= '0;
                        best_cnt_q <= '0;
                        tie_q      <= 1'b0;
                        no_spike_q <= 1'b0;
                    end
                end
                StScan: begin
                    best_cnt_q <= scan_best;
                    if (scan_take) begin
                        best_idx_q <= scan_idx_q;
                        tie_q      <= 1'b0;
                    end else if (scan_cnt == best_cnt_q && best_cnt_q != '0) begin
                        tie_q <= 1'b1;
                    end
                    scan_idx_q <= scan_idx_q + 1'b1;
                    if (scan_last) begin
                        state_q    <= StDone;
                        valid_q    <= 1'b1;
                        no_spike_q <= (scan_best == '0);
                    end
                end
                StDone: begin
                    if (res.result_ready) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational counter readback; out-of-range selects read as zero.
    always_comb begin
        cnt_dout_o = '0;
        if (32'(cnt_sel_i) < NUM_NEURONS) begin
            cnt_dout_o = cnt_q[cnt_sel_i];
        end
    end

    assign busy_o           = busy_q;
    assign res.result_valid = valid_q;
    assign res.winner_idx   = best_idx_q;
    assign res.winner_count = best_cnt_q;
    assign res.tie          = tie_q;
    assign res.no_spike     = no_spike_q;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Bench for spike_count_classifier: two instances (4-bit and 3-bit counters) share the
// same stimulus; results are compared with a plain-arithmetic model of the window.
module tb_spike_count_classifier;
    localparam int unsigned NN  = 4;
    localparam int unsigned NS  = 10;
    localparam int unsigned CW  = 4;
    localparam int unsigned CW3 = 3;
    localparam int unsigned IW  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NN-1:0] spike;
    logic [IW-1:0] cnt_sel;
    logic          busy4, busy3;
    logic [CW-1:0]  dout4;
    logic [CW3-1:0] dout3;

    always #5 clk = ~clk;

    spike_count_classifier_if #(.COUNT_WIDTH(CW),  .IDX_WIDTH(IW)) if4 ();
    spike_count_classifier_if #(.COUNT_WIDTH(CW3), .IDX_WIDTH(IW)) if3 ();

    spike_count_classifier #(.NUM_NEURONS(NN), .COUNT_WIDTH(CW), .NUM_STEPS(NS)) dut4 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .spike_in_i (spike),
        .busy_o     (busy4),
        .cnt_sel_i  (cnt_sel),
        .cnt_dout_o (dout4),
        .res        (if4)
    );

    spike_count_classifier #(.NUM_NEURONS(NN), .COUNT_WIDTH(CW3), .NUM_STEPS(NS)) dut3 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .spike_in_i (spike),
        .busy_o     (busy3),
        .cnt_sel_i  (cnt_sel),
        .cnt_dout_o (dout3),
        .res        (if3)
    );

    int tests = 0;
    int fails = 0;
    logic [NN-1:0] pat [NS];

    // Model outputs for one counter width.
    int m_cnt [NN];
    int m_idx, m_count, m_tie, m_none;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        if4.result_ready = v;
        if3.result_ready = v;
    endtask

    function automatic int sat_count(input int i, input int w);
        int s = 0;
        for (int k = 0; k < NS; k++) s += int'(pat[k][i]);
        return (s > (1 << w) - 1) ? (1 << w) - 1 : s;
    endfunction

    // Winner = maximum count, first index holding it; tie if the maximum occurs twice.
    task automatic model(input int w);
        int n_at_max;
        m_count = 0;
        for (int i = 0; i < NN; i++) begin
            m_cnt[i] = sat_count(i, w);
            if (m_cnt[i] > m_count) m_count = m_cnt[i];
        end
        m_idx = -1;
        n_at_max = 0;
        for (int i = 0; i < NN; i++) begin
            if (m_cnt[i] == m_count) begin
                n_at_max++;
                if (m_idx < 0) m_idx = i;
            end
        end
        m_tie  = (m_count > 0 && n_at_max > 1) ? 1 : 0;
        m_none = (m_count == 0) ? 1 : 0;
    endtask

    task automatic fill_fixed(input logic [NN-1:0] v);
        for (int k = 0; k < NS; k++) pat[k] = v;
    endtask

    task automatic fill_random(input int density);
        for (int k = 0; k < NS; k++) begin
            for (int i = 0; i < NN; i++) pat[k][i] = ($urandom_range(0, 3) < density);
        end
    endtask

    task automatic check_fields(input string tag);
        model(CW);
        check({tag, "_idx4"},  32'(if4.winner_idx),   m_idx);
        check({tag, "_cnt4"},  32'(if4.winner_count), m_count);
        check({tag, "_tie4"},  32'(if4.tie),          m_tie);
        check({tag, "_none4"}, 32'(if4.no_spike),     m_none);
        model(CW3);
        check({tag, "_idx3"},  32'(if3.winner_idx),   m_idx);
        check({tag, "_cnt3"},  32'(if3.winner_count), m_count);
        check({tag, "_tie3"},  32'(if3.tie),          m_tie);
        check({tag, "_none3"}, 32'(if3.no_spike),     m_none);
    endtask

    task automatic check_counters(input string tag);
        for (int i = 0; i < NN; i++) begin
            cnt_sel = IW'(i);
            #1;
            model(CW);
            check({tag, "_dout4"}, 32'(dout4), m_cnt[i]);
            model(CW3);
            check({tag, "_dout3"}, 32'(dout3), m_cnt[i]);
        end
    endtask

    // Start a window with the current pattern and wait (bounded) for the result.
    task automatic run_window(input string tag);
        int n;
        start = 1'b1;
        spike = NN'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy4 & busy3), 1);
        for (int k = 0; k < NS; k++) begin
            spike = pat[k];
            @(posedge clk); #1;
        end
        spike = NN'($urandom);
        n = 0;
        while (!if4.result_valid && n < int'(NN) + 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, NS + n, NS + NN);
        check({tag, "_valid3"}, 32'(if3.result_valid), 1);
        check_fields(tag);
        check_counters(tag);
    endtask

    // Accept the result with start asserted in the same cycle; start must be ignored.
    task automatic handshake(input string tag);
        set_ready(1'b1);
        start = 1'b1;
        spike = NN'($urandom);
        @(posedge clk); #1;
        check({tag, "_hs_valid"}, 32'({if4.result_valid, if3.result_valid}), 0);
        check({tag, "_hs_busy"},  32'({busy4, busy3}), 0);
        set_ready(1'b0);
        start = 1'b0;
        spike = NN'($urandom);
        @(posedge clk); #1;
        check({tag, "_idle_busy"}, 32'({busy4, busy3}), 0);
        check_fields({tag, "_held"});
        check_counters({tag, "_kept"});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},  32'({busy4, busy3}), 0);
        check({tag, "_valid"}, 32'({if4.result_valid, if3.result_valid}), 0);
        check({tag, "_idx"},   32'({if4.winner_idx, if3.winner_idx}), 0);
        check({tag, "_cnt"},   32'({if4.winner_count, if3.winner_count}), 0);
        check({tag, "_flags"}, 32'({if4.tie, if4.no_spike, if3.tie, if3.no_spike}), 0);
        for (int i = 0; i < NN; i++) begin
            cnt_sel = IW'(i);
            #1;
            check({tag, "_dout"}, 32'({dout4, dout3}), 0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        spike   = '0;
        cnt_sel = '0;
        set_ready(1'b0);
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single active neuron.
        fill_fixed(4'b0100);
        run_window("t1");
        handshake("t1");

        // Neurons 1 and 3 tie at 5, neuron 0 at 2.
        for (int k = 0; k < NS; k++) begin
            pat[k] = {k < 5, 1'b0, k >= 5, k < 2};
        end
        run_window("t2");
        handshake("t2");

        // All neurons fire every step: 3-bit counters saturate at 7.
        fill_fixed(4'b1111);
        run_window("t3");
        handshake("t3");

        // Silent window.
        fill_fixed(4'b0000);
        run_window("t6");
        handshake("t6");

        // Consumer back-pressure with start pulses while DONE.
        fill_random(2);
        run_window("t4");
        for (int c = 0; c < 20; c++) begin
            start = (c % 3 == 0);
            spike = NN'($urandom);
            @(posedge clk); #1;
            check("t4_stall_busy",  32'({busy4, busy3}), 2'b11);
            check("t4_stall_valid", 32'({if4.result_valid, if3.result_valid}), 2'b11);
            model(CW);
            check("t4_stall_idx4", 32'(if4.winner_idx),   m_idx);
            check("t4_stall_cnt4", 32'(if4.winner_count), m_count);
            check("t4_stall_tie4", 32'(if4.tie),          m_tie);
        end
        start = 1'b0;
        handshake("t4");

        // Reset in the middle of the counting window.
        fill_random(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            spike = pat[k];
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_reset_state("t5_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_no_result", 32'({if4.result_valid, if3.result_valid, busy4, busy3}), 0);
        fill_random(2);
        run_window("t5");
        handshake("t5");

        // Randomised windows at varying spike densities.
        for (int r = 0; r < 8; r++) begin
            fill_random($urandom_range(0, 4));
            run_window("rand");
            handshake("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
